mem_arbiter_2way: RTL and testbench

Shares the single DRAM request/response FIFO port between two cache-line requesters: requester 0 is the L1 data cache and requester 1 is the instruction cache or a second L1 instance. It grants requesters round-robin and keeps one transaction outstanding at a time. Responses are routed back to the granted requester. Writes are acknowledged on acceptance; reads are acknowledged on the returned line. The block also adds a response timeout and sticky error reporting.

---
 rtl/mem_arbiter_2way_if.sv | 52 +++++
 rtl/mem_arbiter_2way.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter_2way.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_2way_if.sv
// Bundle of the two cache requester ports, the DRAM FIFO port and the status
// outputs of the two-way memory arbiter.
interface mem_arbiter_2way_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_data;
    logic              r0_rw;
    logic              r0_valid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_ready;

    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_data;
    logic              r1_rw;
    logic              r1_valid;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_ready;

    logic              mem_req_cmd;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_req_en;
    logic              mem_req_rdy;
    logic              mem_rsp_en;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              mem_rsp_rdy;

    logic              busy;
    logic [1:0]        err;

    modport slave (
        input  r0_addr, r0_data, r0_rw, r0_valid,
        output r0_rdata, r0_ready,
        input  r1_addr, r1_data, r1_rw, r1_valid,
        output r1_rdata, r1_ready,
        output mem_req_cmd, mem_req_addr, mem_req_data, mem_req_en,
        input  mem_req_rdy, mem_rsp_en, mem_rsp_data,
        output mem_rsp_rdy, busy, err
    );

    modport master (
        output r0_addr, r0_data, r0_rw, r0_valid,
        input  r0_rdata, r0_ready,
        output r1_addr, r1_data, r1_rw, r1_valid,
        input  r1_rdata, r1_ready,
        input  mem_req_cmd, mem_req_addr, mem_req_data, mem_req_en,
        output mem_req_rdy, mem_rsp_en, mem_rsp_data,
        input  mem_rsp_rdy, busy, err
    );
endinterface

// File: rtl/mem_arbiter_2way.sv
// Round-robin arbiter sharing one DRAM request/response FIFO between two
// cache requesters, one transaction outstanding, with timeout and sticky errors.
module mem_arbiter_2way #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 1023
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_2way_if.slave bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The last WAIT_RSP cycle is the one whose count is TIMEOUT-1.
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, ACK} state_t;

    state_t            state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              last_grant_reg, last_grant_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              rw_reg, rw_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [1:0]        err_reg, err_next;
    logic [DATA_W-1:0] ack_data;

    logic              req_en_reg, req_cmd_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_data_reg;
    logic              ready0_reg, ready1_reg;
    logic [DATA_W-1:0] rdata0_reg, rdata1_reg;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        rw_next         = rw_reg;
        count_next      = count_reg;
        err_next        = err_reg;
        ack_data        = '0;

        if (bus.mem_rsp_en && state_reg != WAIT_RSP)
            err_next[1] = 1'b1;

        case (state_reg)
            IDLE: begin
                if (bus.r0_valid && (!bus.r1_valid || last_grant_reg)) begin
                    grant_next = 1'b0;
                    addr_next  = bus.r0_addr;
                    data_next  = bus.r0_data;
                    rw_next    = bus.r0_rw;
                    state_next = ISSUE;
                end else if (bus.r1_valid) begin
                    grant_next = 1'b1;
                    addr_next  = bus.r1_addr;
                    data_next  = bus.r1_data;
                    rw_next    = bus.r1_rw;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_rdy) begin
                    if (rw_reg) begin
                        state_next = ACK;
                    end else begin
                        state_next = WAIT_RSP;
                        count_next = '0;
                    end
                end
            end
            WAIT_RSP: begin
                count_next = count_reg + 1'b1;
                // A response arriving on the final cycle beats the timeout.
                if (bus.mem_rsp_en) begin
                    ack_data   = bus.mem_rsp_data;
                    state_next = ACK;
                end else if (TIMEOUT != 0 && count_reg == TO_LAST) begin
                    err_next[0] = 1'b1;
                    state_next  = ACK;
                end
            end
            ACK: begin
                last_grant_next = grant_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are derived from the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            addr_reg       <= '0;
            data_reg       <= '0;
            rw_reg         <= 1'b0;
            count_reg      <= '0;
            err_reg        <= 2'b00;
            req_en_reg     <= 1'b0;
            req_cmd_reg    <= 1'b0;
            req_addr_reg   <= '0;
            req_data_reg   <= '0;
            ready0_reg     <= 1'b0;
            ready1_reg     <= 1'b0;
            rdata0_reg     <= '0;
            rdata1_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            rw_reg         <= rw_next;
            count_reg      <= count_next;
            err_reg        <= err_next;
            req_en_reg     <= (state_next == ISSUE);
            req_cmd_reg    <= (state_next == ISSUE) && !rw_next;
            req_addr_reg   <= (state_next == ISSUE) ? addr_next : '0;
            req_data_reg   <= (state_next == ISSUE && rw_next) ? data_next : '0;
            ready0_reg     <= (state_next == ACK) && !grant_next;
            ready1_reg     <= (state_next == ACK) && grant_next;
            rdata0_reg     <= (state_next == ACK && !grant_next) ? ack_data : '0;
            rdata1_reg     <= (state_next == ACK && grant_next) ? ack_data : '0;
        end
    end

    assign bus.mem_req_en   = req_en_reg;
    assign bus.mem_req_cmd  = req_cmd_reg;
    assign bus.mem_req_addr = req_addr_reg;
    assign bus.mem_req_data = req_data_reg;
    assign bus.mem_rsp_rdy  = 1'b1;
    assign bus.r0_ready     = ready0_reg;
    assign bus.r1_ready     = ready1_reg;
    assign bus.r0_rdata     = rdata0_reg;
    assign bus.r1_rdata     = rdata1_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.err          = err_reg;
endmodule

// File: tb/tb_mem_arbiter_2way.sv
// Self-checking bench for mem_arbiter_2way: a scoreboard of expected
// completions plus directed latency, fairness, timeout, error and reset checks.
module tb_mem_arbiter_2way;
    localparam int AW = 27;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_2way_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_arbiter_2way #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        n_checks++;
        if (obs !== want)
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        else
            n_pass++;
    endtask

    task automatic push_exp(input logic id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Returns in the first ISSUE cycle, or reports a failure after the budget.
    task automatic wait_req();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_req_en) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_wait_expired", 1, 0);
    endtask

    // Accepts a read immediately, answers after 'delay' extra cycles; returns in ACK.
    task automatic serve_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input int delay);
        bus.mem_req_rdy = 1'b1;
        wait_req();
        check("rd_addr", bus.mem_req_addr, a);
        check("rd_cmd", bus.mem_req_cmd, 1);
        tick();
        repeat (delay) tick();
        bus.mem_rsp_en   = 1'b1;
        bus.mem_rsp_data = d;
        tick();
        bus.mem_rsp_en   = 1'b0;
        bus.mem_rsp_data = '0;
    endtask

    // Scoreboard: every completion pulse must match the next expected entry.
    always @(negedge clk) begin
        if (bus.r0_ready || bus.r1_ready) begin : mon
            exp_t e;
            logic id;
            id = bus.r1_ready;
            $display("txn: r%0d ready rdata=%h", id, id ? bus.r1_rdata : bus.r0_rdata);
            check("one_ready", bus.r0_ready & bus.r1_ready, 0);
            if (sb.size() == 0) begin
                check("unexpected_ready", 1, 0);
            end else begin
                e = sb.pop_front();
                check("grant_id", id, e.id);
                check("rdata", id ? bus.r1_rdata : bus.r0_rdata, e.data);
                check("other_rdata", id ? bus.r0_rdata : bus.r1_rdata, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] a0, a1;

    initial begin
        bus.r0_addr = '0; bus.r0_data = '0; bus.r0_rw = 1'b0; bus.r0_valid = 1'b0;
        bus.r1_addr = '0; bus.r1_data = '0; bus.r1_rw = 1'b0; bus.r1_valid = 1'b0;
        bus.mem_req_rdy = 1'b1; bus.mem_rsp_en = 1'b0; bus.mem_rsp_data = '0;

        do_reset();
        check("rst_req_en", bus.mem_req_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_rsp_rdy", bus.mem_rsp_rdy, 1);
        check("rst_r0_ready", bus.r0_ready, 0);
        check("rst_req_addr", bus.mem_req_addr, 0);

        // r0 write, FIFO always ready
        bus.r0_addr  = 27'h2aaaaa8;
        bus.r0_data  = 128'h1c71c71c_33333333_00000000_00000000;
        bus.r0_rw    = 1'b1;
        bus.r0_valid = 1'b1;
        push_exp(1'b0, '0);
        tick();
        check("wr_en_t1", bus.mem_req_en, 1);
        check("wr_cmd", bus.mem_req_cmd, 0);
        check("wr_addr", bus.mem_req_addr, 27'h2aaaaa8);
        check("wr_data", bus.mem_req_data, 128'h1c71c71c_33333333_00000000_00000000);
        check("wr_ready_t1", bus.r0_ready, 0);
        tick();
        check("wr_ready_t2", bus.r0_ready, 1);
        check("wr_r1_ready", bus.r1_ready, 0);
        check("wr_en_t2", bus.mem_req_en, 0);
        bus.r0_valid = 1'b0;
        tick();
        check("wr_busy_t3", bus.busy, 0);

        // r1 read with FIFO back-pressure for 3 cycles
        bus.mem_req_rdy = 1'b0;
        bus.r1_addr  = 27'h61827b8;
        bus.r1_data  = 128'hffff;
        bus.r1_rw    = 1'b0;
        bus.r1_valid = 1'b1;
        push_exp(1'b1, 128'hdeadbeef);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_en_held", bus.mem_req_en, 1);
            check("rd_cmd_held", bus.mem_req_cmd, 1);
            check("rd_data_zero", bus.mem_req_data, 0);
            check("rd_addr_held", bus.mem_req_addr, 27'h61827b8);
            if (i == 3) bus.mem_req_rdy = 1'b1;
            tick();
        end
        check("rd_en_drop", bus.mem_req_en, 0);
        check("rd_busy", bus.busy, 1);
        repeat (3) tick();
        bus.mem_rsp_en   = 1'b1;
        bus.mem_rsp_data = 128'hdeadbeef;
        tick();
        bus.mem_rsp_en   = 1'b0;
        bus.mem_rsp_data = '0;
        check("rd_r1_ready", bus.r1_ready, 1);
        check("rd_r1_rdata", bus.r1_rdata, 128'hdeadbeef);
        bus.r1_valid = 1'b0;
        tick();
        check("rd_r1_ready_pulse", bus.r1_ready, 0);

        // Fairness: both requesters continuously valid from reset
        do_reset();
        a0 = 27'h100;
        a1 = 27'h200;
        bus.r0_addr = a0; bus.r0_rw = 1'b0; bus.r0_valid = 1'b1;
        bus.r1_addr = a1; bus.r1_rw = 1'b0; bus.r1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [DW-1:0] d;
            d = 128'h5000 + DW'(k);
            push_exp(k[0], d);
            serve_read(k[0] ? a1 : a0, d, 1);
            if (k[0]) begin a1 = a1 + 27'h8; bus.r1_addr = a1; end
            else      begin a0 = a0 + 27'h8; bus.r0_addr = a0; end
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        tick();
        check("fair_err", bus.err, 0);

        // Response on the final WAIT_RSP cycle wins over the timeout
        bus.r0_addr = 27'h300; bus.r0_rw = 1'b0; bus.r0_valid = 1'b1;
        push_exp(1'b0, 128'hcafe);
        wait_req();
        tick();
        repeat (6) tick();
        check("edge_no_ready", bus.r0_ready, 0);
        tick();
        bus.mem_rsp_en   = 1'b1;
        bus.mem_rsp_data = 128'hcafe;
        tick();
        bus.mem_rsp_en   = 1'b0;
        bus.mem_rsp_data = '0;
        bus.r0_valid = 1'b0;
        check("edge_ready", bus.r0_ready, 1);
        check("edge_err", bus.err, 0);
        tick();

        // Timeout: no response ever arrives
        bus.r0_addr = 27'h308; bus.r0_valid = 1'b1;
        push_exp(1'b0, '0);
        wait_req();
        tick();
        repeat (7) tick();
        check("to_c8_ready", bus.r0_ready, 0);
        check("to_c8_busy", bus.busy, 1);
        tick();
        check("to_c9_ready", bus.r0_ready, 1);
        check("to_err", bus.err, 2'b01);
        bus.r0_valid = 1'b0;
        tick();

        // Good read afterwards keeps err sticky
        bus.r0_addr = 27'h310; bus.r0_valid = 1'b1;
        push_exp(1'b0, 128'h1234_5678);
        serve_read(27'h310, 128'h1234_5678, 2);
        bus.r0_valid = 1'b0;
        check("sticky_err", bus.err, 2'b01);
        tick();

        // Stray response while IDLE
        bus.mem_rsp_en   = 1'b1;
        bus.mem_rsp_data = 128'hbad;
        tick();
        bus.mem_rsp_en   = 1'b0;
        bus.mem_rsp_data = '0;
        check("stray_err", bus.err, 2'b11);
        check("stray_busy", bus.busy, 0);
        tick();
        check("stray_busy2", bus.busy, 0);

        // Reset during WAIT_RSP, then a late response
        bus.r1_addr = 27'h400; bus.r1_rw = 1'b0; bus.r1_valid = 1'b1;
        wait_req();
        tick();
        tick();
        rst = 1'b1;
        bus.r1_valid = 1'b0;
        tick();
        check("rst_mid_en", bus.mem_req_en, 0);
        check("rst_mid_r0", bus.r0_ready, 0);
        check("rst_mid_r1", bus.r1_ready, 0);
        check("rst_mid_rdata", bus.r1_rdata, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_err", bus.err, 0);
        check("rst_mid_rsp_rdy", bus.mem_rsp_rdy, 1);
        rst = 1'b0;
        tick();
        bus.mem_rsp_en   = 1'b1;
        bus.mem_rsp_data = 128'h77;
        tick();
        bus.mem_rsp_en   = 1'b0;
        bus.mem_rsp_data = '0;
        check("late_err", bus.err, 2'b10);
        check("late_busy", bus.busy, 0);

        // Both request after reset: requester 0 preferred
        bus.r0_addr = 27'h500; bus.r0_data = 128'haaaa; bus.r0_rw = 1'b1; bus.r0_valid = 1'b1;
        bus.r1_addr = 27'h600; bus.r1_data = 128'hbbbb; bus.r1_rw = 1'b1; bus.r1_valid = 1'b1;
        push_exp(1'b0, '0);
        wait_req();
        check("post_rst_addr", bus.mem_req_addr, 27'h500);
        check("post_rst_cmd", bus.mem_req_cmd, 0);
        check("post_rst_data", bus.mem_req_data, 128'haaaa);
        tick();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        repeat (3) tick();
        check("sb_leftover", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
